// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART receive controller.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned OVERSAMPLE_DEF = 8;
  localparam int unsigned HALF           = OVERSAMPLE_DEF / 2;
  localparam int unsigned STROBE_PT      = HALF + 2;
  localparam int unsigned MAX_DATA_W     = 9;

  // Strobe point for an arbitrary oversample ratio: the sampler then holds HALF-1..HALF+1.
  function automatic int unsigned strobe_pt(input int unsigned oversample);
    return (oversample / 2) + 2;
  endfunction

  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-cell timing: edge counter within a cell plus data-bit counter.
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             bit_clr_i,
  input  logic             bit_inc_i,
  output logic [BIT_W-1:0] bit_cnt_o,
  output logic             strobe_o,
  output logic             cell_end_o,
  output logic             last_bit_o
);

  localparam int unsigned EDGE_W = $clog2(OVERSAMPLE);
  localparam logic [EDGE_W-1:0] STROBE_AT = EDGE_W'(strobe_pt(OVERSAMPLE));
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(OVERSAMPLE - 1);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // The detection cycle itself is edge 0 of the start cell, so the counter resumes at 1.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (start_i) begin
      edge_cnt_d = EDGE_ONE;
    end else if (run_i) begin
      edge_cnt_d = (edge_cnt_q == LAST_EDGE) ? {EDGE_W{1'b0}} : edge_cnt_q + EDGE_ONE;
    end else begin
      edge_cnt_d = {EDGE_W{1'b0}};
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (bit_clr_i) begin
      bit_cnt_d = {BIT_W{1'b0}};
    end else if (bit_inc_i) begin
      bit_cnt_d = bit_cnt_q + BIT_ONE;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= {EDGE_W{1'b0}};
      bit_cnt_q  <= {BIT_W{1'b0}};
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bit_cnt_o  = bit_cnt_q;
  assign strobe_o   = run_i && (edge_cnt_q == STROBE_AT);
  assign cell_end_o = run_i && (edge_cnt_q == LAST_EDGE);
  assign last_bit_o = (bit_cnt_q == LAST_BIT);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: frames start/data/parity/stop cells, drives the sampler
// strobes, assembles the LSB-first word and reports parity/framing status per frame.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_odd,
  input  logic                  cfg_vote,
  input  logic                  start_bit_detector,
  input  logic                  sampled_bit,
  output logic                  sampler_enable,
  output logic                  sample_one_bit,
  output logic                  sample_three_bit,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e state_q, state_d;
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
  logic vote_q, vote_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic perr_acc_q, perr_acc_d;
  logic rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic parity_err_q, parity_err_d;
  logic framing_err_q, framing_err_d;

  logic             timer_start_s;
  logic             timer_run_s;
  logic             bit_clr_s;
  logic             bit_inc_s;
  logic [BIT_W-1:0] bit_cnt_s;
  logic             strobe_s;
  logic             cell_end_s;
  logic             last_bit_s;

  assign timer_run_s = (state_q != ST_IDLE);

  uart_rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_WIDTH (DATA_WIDTH),
    .BIT_W      (BIT_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .start_i    (timer_start_s),
    .run_i      (timer_run_s),
    .bit_clr_i  (bit_clr_s),
    .bit_inc_i  (bit_inc_s),
    .bit_cnt_o  (bit_cnt_s),
    .strobe_o   (strobe_s),
    .cell_end_o (cell_end_s),
    .last_bit_o (last_bit_s)
  );

  // Frame sequencing; STOP leaves at its strobe so a back-to-back start edge is not missed.
  always_comb begin
    state_d       = state_q;
    par_en_d      = par_en_q;
    par_odd_d     = par_odd_q;
    vote_d        = vote_q;
    shift_d       = shift_q;
    perr_acc_d    = perr_acc_q;
    rx_valid_d    = 1'b0;
    rx_data_d     = rx_data_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    timer_start_s = 1'b0;
    bit_clr_s     = 1'b0;
    bit_inc_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_bit_detector) begin
          state_d       = ST_START;
          timer_start_s = 1'b1;
          par_en_d      = cfg_par_en;
          par_odd_d     = cfg_par_odd;
          vote_d        = cfg_vote;
          perr_acc_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (strobe_s) begin
          state_d = sampled_bit ? ST_IDLE : ST_START;
        end else if (cell_end_s) begin
          state_d   = ST_DATA;
          bit_clr_s = 1'b1;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (strobe_s) begin
          shift_d[bit_cnt_s] = sampled_bit;
        end else if (cell_end_s) begin
          if (last_bit_s) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_inc_s = 1'b1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (strobe_s) begin
          perr_acc_d = sampled_bit ^ calc_parity(MAX_DATA_W'(shift_q), par_odd_q);
        end else if (cell_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (strobe_s) begin
          state_d       = ST_IDLE;
          rx_valid_d    = 1'b1;
          rx_data_d     = shift_q;
          parity_err_d  = par_en_q & perr_acc_q;
          framing_err_d = ~sampled_bit;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      vote_q        <= 1'b0;
      shift_q       <= {DATA_WIDTH{1'b0}};
      perr_acc_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= {DATA_WIDTH{1'b0}};
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      par_en_q      <= par_en_d;
      par_odd_q     <= par_odd_d;
      vote_q        <= vote_d;
      shift_q       <= shift_d;
      perr_acc_q    <= perr_acc_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Sampler controls must act in the same cycle as the line/counter they depend on.
  assign sampler_enable   = ~rst & (timer_run_s | start_bit_detector);
  assign sample_three_bit = ~rst & strobe_s & vote_q;
  assign sample_one_bit   = ~rst & strobe_s & ~vote_q;

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller with a behavioural 3-tap sampler and frame scoreboard.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_par_en = 1'b0;
  logic       cfg_par_odd = 1'b0;
  logic       cfg_vote = 1'b1;
  logic       line = 1'b1;
  logic       start_bit_detector;
  logic       sampled_bit;
  logic       sampler_enable;
  logic       sample_one_bit;
  logic       sample_three_bit;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       busy;

  logic [2:0] smp = 3'b111;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  uart_rx_controller #(.OVERSAMPLE(8), .DATA_WIDTH(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_par_en         (cfg_par_en),
    .cfg_par_odd        (cfg_par_odd),
    .cfg_vote           (cfg_vote),
    .start_bit_detector (start_bit_detector),
    .sampled_bit        (sampled_bit),
    .sampler_enable     (sampler_enable),
    .sample_one_bit     (sample_one_bit),
    .sample_three_bit   (sample_three_bit),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .parity_err         (parity_err),
    .framing_err        (framing_err),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sampler model: smp[1] is the middle of the three most recent enabled line samples.
  assign start_bit_detector = ~line;
  always @(posedge clk) if (sampler_enable) smp <= {smp[1:0], line};
  assign sampled_bit = sample_three_bit ?
      ((smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2])) : smp[1];

  initial begin
    forever begin
      @(negedge clk);
      if (sample_one_bit || sample_three_bit) begin
        n_checks++;
        if (sample_one_bit && sample_three_bit) begin
          n_fail++;
          $display("FAIL strobe_exclusive: both strobes high at cycle %0d, required one", cyc);
        end
      end
      if (rx_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rx_valid: got data=%h at cycle %0d, required no frame", rx_data, cyc);
        end else begin
          e_mon = exp_q.pop_front();
          if (rx_data !== e_mon.data || parity_err !== e_mon.perr ||
              framing_err !== e_mon.ferr || cyc != e_mon.due) begin
            n_fail++;
            $display("FAIL frame: got data=%h perr=%b ferr=%b cycle=%0d, required data=%h perr=%b ferr=%b cycle=%0d",
                     rx_data, parity_err, framing_err, cyc, e_mon.data, e_mon.perr, e_mon.ferr, e_mon.due);
          end
        end
      end
    end
  end

  // Called aligned at posedge+1; returns aligned at the cycle after the stop cell.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic vote, input logic flip_par, input logic stop_v,
                            input logic noise, input logic [7:0] exp_d);
    exp_t       e;
    logic [10:0] bits;
    int         nbits;
    bits = {1'b1, 1'b1, 1'b1, d, 1'b0};
    if (pen) begin
      bits[9]  = (^d) ^ podd ^ flip_par;
      bits[10] = stop_v;
      nbits    = 11;
    end else begin
      bits[9]  = stop_v;
      nbits    = 10;
    end
    e.data = exp_d;
    e.perr = pen & flip_par;
    e.ferr = ~stop_v;
    e.due  = cyc + (pen ? 87 : 79);
    exp_q.push_back(e);
    cfg_par_en  = pen;
    cfg_par_odd = podd;
    cfg_vote    = vote;
    for (int c = 0; c < nbits; c++) begin
      for (int k = 0; k < 8; k++) begin
        line = bits[c] ^ (noise && c >= 1 && c <= 8 && k == 4);
        if (c == 0 && k == 1) begin
          cfg_par_en  = ~pen;
          cfg_par_odd = ~podd;
          cfg_vote    = ~vote;
        end
        @(posedge clk); #1;
      end
    end
    line = 1'b1;
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_frame: %0d frames pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_valid, busy, rx_data, parity_err, framing_err, sampler_enable,
         sample_one_bit, sample_three_bit} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b data=%h perr=%b ferr=%b en=%b, required all 0",
               rx_valid, busy, rx_data, parity_err, framing_err, sampler_enable);
    end
    rst = 1'b0;
    idle(4);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_hold: got valid=%b data=%h, required valid=0 data=a5", rx_valid, rx_data);
    end
    idle(5);
    check_drained("basic");
  endtask

  task automatic test_glitch;
    cfg_vote = 1'b1;
    for (int k = 0; k < 10; k++) begin
      line = (k < 3) ? 1'b0 : 1'b1;
      #1;
      if (k == 0) begin
        n_checks++;
        if (sampler_enable !== 1'b1) begin
          n_fail++;
          $display("FAIL glitch_sampler_enable: got %b, required 1", sampler_enable);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL glitch_busy_start: got %b, required 1", busy);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_busy_drop: got %b at cycle 7, required 0", busy);
        end
      end
      @(posedge clk); #1;
    end
    idle(10);
    check_drained("glitch");
  endtask

  task automatic test_parity;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
    idle(3);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03);
    idle(3);
    send_frame(8'h6B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6B);
    idle(3);
    check_drained("parity");
  endtask

  task automatic test_framing;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81);
    idle(40);
    n_checks++;
    if (busy !== 1'b0 || framing_err !== 1'b1) begin
      n_fail++;
      $display("FAIL framing_rearm: got busy=%b ferr=%b, required busy=0 ferr=1", busy, framing_err);
    end
    check_drained("framing");
  endtask

  task automatic test_noise;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    idle(2);
    check_drained("noise");
  endtask

  task automatic test_back_to_back;
    cfg_vote = 1'b1;
    cfg_par_en = 1'b0;
    line = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %b, required 1", busy);
    end
    rst  = 1'b1;
    line = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({rx_valid, busy, rx_data, parity_err, framing_err, sampler_enable} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b busy=%b data=%h perr=%b ferr=%b en=%b, required all 0",
               rx_valid, busy, rx_data, parity_err, framing_err, sampler_enable);
    end
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C);
    idle(4);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    idle(10);
    check_drained("back_to_back");
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_glitch;
    test_parity;
    test_framing;
    test_noise;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
